// File: rtl/tx_lane_scheduler_if.sv
// Handshake and transmitter-side bus between the data sources and the lane scheduler.
interface tx_lane_scheduler_if;
    logic        enb;
    logic        req8;
    logic        req16;
    logic        req32;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [31:0] din32;
    logic        ack8;
    logic        ack16;
    logic        ack32;
    logic [1:0]  dataS;
    logic [7:0]  dataIn;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;
    logic        K;
    logic        busy;

    // Source side: drives requests and data, receives grants and transmitter outputs.
    modport master (
        output enb, req8, req16, req32, din8, din16, din32,
        input  ack8, ack16, ack32, dataS, dataIn, dataIn16, dataIn32, K, busy
    );

    // Scheduler side.
    modport slave (
        input  enb, req8, req16, req32, din8, din16, din32,
        output ack8, ack16, ack32, dataS, dataIn, dataIn16, dataIn32, K, busy
    );
endinterface

// File: rtl/tx_lane_scheduler.sv
// Round-robin width scheduler feeding the PCIe transmitter, with COM idle fill
// and periodic COM+SKP insertion at frame boundaries.
module tx_lane_scheduler #(
    parameter int unsigned SKIP_INTERVAL = 64,
    parameter logic [7:0]  COM           = 8'hBC,
    parameter logic [7:0]  SKP           = 8'h1C
) (
    input logic              clk,
    input logic              rst,
    tx_lane_scheduler_if.slave bus
);

    localparam int unsigned CNT_W = (SKIP_INTERVAL > 1) ? $clog2(SKIP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKIP_INTERVAL - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_SKIP = 2'd2} state_e;
    typedef enum logic [1:0] {W8 = 2'd0, W16 = 2'd1, W32 = 2'd2} width_e;

    state_e           state_q, state_d;
    width_e           last_q, last_d;
    logic [1:0]       rem_q, rem_d;
    logic             slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    logic [1:0]       data_s_q, data_s_d;
    logic [7:0]       data_in_q, data_in_d;
    logic [15:0]      data_in16_q, data_in16_d;
    logic [31:0]      data_in32_q, data_in32_d;
    logic             k_q, k_d;
    logic             busy_q, busy_d;

    logic             bnd_c;
    logic             gnt_valid_c;
    width_e           gnt_w_c;
    logic             take_grant_c;

    // Round-robin pick: first requester after the last winner in 8->16->32 order.
    always_comb begin
        gnt_w_c     = W8;
        gnt_valid_c = bus.req8 | bus.req16 | bus.req32;
        case (last_q)
            W8: begin
                if (bus.req16)      gnt_w_c = W16;
                else if (bus.req32) gnt_w_c = W32;
                else                gnt_w_c = W8;
            end
            W16: begin
                if (bus.req32)      gnt_w_c = W32;
                else if (bus.req8)  gnt_w_c = W8;
                else                gnt_w_c = W16;
            end
            default: begin
                if (bus.req8)       gnt_w_c = W8;
                else if (bus.req16) gnt_w_c = W16;
                else                gnt_w_c = W32;
            end
        endcase
    end

    // Boundary detection, next state, slot/skip counters and grant decision.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        rem_d        = rem_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        take_grant_c = 1'b0;

        bnd_c = (state_q == ST_IDLE) ||
                (state_q == ST_SEND && rem_q == 2'd0) ||
                (state_q == ST_SKIP && slot_q);

        if (bus.enb) begin
            if (state_q == ST_SEND && rem_q != 2'd0) rem_d = rem_q - 2'd1;
            if (state_q == ST_SKIP) slot_d = 1'b1;

            if (bnd_c) begin
                if (pend_q) begin
                    state_d = ST_SKIP;
                    slot_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (gnt_valid_c) begin
                    take_grant_c = 1'b1;
                    state_d      = ST_SEND;
                    last_d       = gnt_w_c;
                    case (gnt_w_c)
                        W8:      rem_d = 2'd0;
                        W16:     rem_d = 2'd1;
                        default: rem_d = 2'd3;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // A newly expiring interval always leaves a skip pending.
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Grants and next values of the registered transmitter outputs.
    always_comb begin
        data_s_d    = data_s_q;
        data_in_d   = data_in_q;
        data_in16_d = data_in16_q;
        data_in32_d = data_in32_q;
        k_d         = k_q;
        busy_d      = busy_q;

        bus.ack8  = rst & take_grant_c & (gnt_w_c == W8);
        bus.ack16 = rst & take_grant_c & (gnt_w_c == W16);
        bus.ack32 = rst & take_grant_c & (gnt_w_c == W32);

        if (bus.enb) begin
            if (take_grant_c) begin
                k_d      = 1'b0;
                busy_d   = 1'b1;
                data_s_d = gnt_w_c;
                case (gnt_w_c)
                    W8:      data_in_d   = bus.din8;
                    W16:     data_in16_d = bus.din16;
                    default: data_in32_d = bus.din32;
                endcase
            end else begin
                case (state_d)
                    ST_IDLE: begin
                        k_d       = 1'b1;
                        busy_d    = 1'b0;
                        data_s_d  = 2'b00;
                        data_in_d = COM;
                    end
                    ST_SKIP: begin
                        k_d       = 1'b1;
                        busy_d    = 1'b1;
                        data_s_d  = 2'b00;
                        data_in_d = slot_d ? SKP : COM;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= W32;
            rem_q       <= 2'd0;
            slot_q      <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            data_s_q    <= 2'b00;
            data_in_q   <= COM;
            data_in16_q <= 16'h0;
            data_in32_q <= 32'h0;
            k_q         <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rem_q       <= rem_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            data_s_q    <= data_s_d;
            data_in_q   <= data_in_d;
            data_in16_q <= data_in16_d;
            data_in32_q <= data_in32_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dataS    = data_s_q;
    assign bus.dataIn   = data_in_q;
    assign bus.dataIn16 = data_in16_q;
    assign bus.dataIn32 = data_in32_q;
    assign bus.K        = k_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: reset, widths, round robin, skip, freeze, abort.
module tb_tx_lane_scheduler;

    logic clk;
    logic rst;

    tx_lane_scheduler_if bus ();
    tx_lane_scheduler_if bus_s ();

    tx_lane_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tx_lane_scheduler #(.SKIP_INTERVAL(16)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_chk;
    int n_fail;

    logic [2:0] rr_ack [0:8];
    logic [1:0] rr_ds  [0:8];
    logic       rr_k   [0:8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".dataS"},  32'(bus.dataS),  32'h0);
        chk({tag, ".dataIn"}, 32'(bus.dataIn), 32'hBC);
        chk({tag, ".K"},      32'(bus.K),      32'h1);
        chk({tag, ".busy"},   32'(bus.busy),   32'h0);
        chk({tag, ".acks"},   32'({bus.ack32, bus.ack16, bus.ack8}), 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rr_ack = '{3'd1, 3'd2, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
        rr_ds  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        rr_k   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        bus.enb = 1'b1;
        bus.req8 = 1'b1; bus.req16 = 1'b0; bus.req32 = 1'b0;
        bus.din8 = 8'h55; bus.din16 = 16'h0; bus.din32 = 32'h0;
        bus_s.enb = 1'b0;
        bus_s.req8 = 1'b0; bus_s.req16 = 1'b0; bus_s.req32 = 1'b0;
        bus_s.din8 = 8'h0; bus_s.din16 = 16'h0; bus_s.din32 = 32'h0;

        // Reset held 3 cycles; req8 high must not be acked while in reset.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rst");
            chk("rst.dataIn16", 32'(bus.dataIn16), 32'h0);
            chk("rst.dataIn32", 32'(bus.dataIn32), 32'h0);
        end
        rst = 1'b1;
        bus.req8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("post_rst");
        end

        // Single 8-bit word.
        bus.req8 = 1'b1; bus.din8 = 8'hCC;
        #1;
        chk("b8.acks", 32'({bus.ack32, bus.ack16, bus.ack8}), 32'h1);
        tick();
        bus.req8 = 1'b0;
        chk("b8.dataIn", 32'(bus.dataIn), 32'hCC);
        chk("b8.K",      32'(bus.K),      32'h0);
        chk("b8.dataS",  32'(bus.dataS),  32'h0);
        chk("b8.busy",   32'(bus.busy),   32'h1);
        tick();
        chk_idle("b8.after");

        // Single 16-bit word: two slots.
        bus.req16 = 1'b1; bus.din16 = 16'hABCD;
        #1;
        chk("b16.acks", 32'({bus.ack32, bus.ack16, bus.ack8}), 32'h2);
        tick();
        bus.req16 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("b16.dataS",    32'(bus.dataS),    32'h1);
            chk("b16.dataIn16", 32'(bus.dataIn16), 32'hABCD);
            chk("b16.K",        32'(bus.K),        32'h0);
            tick();
        end
        chk_idle("b16.after");
        chk("b16.hold16", 32'(bus.dataIn16), 32'hABCD);

        // Single 32-bit word: four slots.
        bus.req32 = 1'b1; bus.din32 = 32'h0123456F;
        #1;
        chk("b32.acks", 32'({bus.ack32, bus.ack16, bus.ack8}), 32'h4);
        tick();
        bus.req32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b32.dataS",    32'(bus.dataS),    32'h2);
            chk("b32.dataIn32", 32'(bus.dataIn32), 32'h0123456F);
            chk("b32.K",        32'(bus.K),        32'h0);
            tick();
        end
        chk_idle("b32.after");

        // Round robin with all requesters held; frames abut with no idle gap.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req8 = 1'b1; bus.req16 = 1'b1; bus.req32 = 1'b1;
        bus.din8 = 8'hA1; bus.din16 = 16'hB2B2; bus.din32 = 32'hC3C3C3C3;
        #1;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("rr.c%0d.acks", c), 32'({bus.ack32, bus.ack16, bus.ack8}), 32'(rr_ack[c]));
            chk($sformatf("rr.c%0d.dataS", c), 32'(bus.dataS), 32'(rr_ds[c]));
            chk($sformatf("rr.c%0d.K", c), 32'(bus.K), 32'(rr_k[c]));
            if (c == 1) chk("rr.dataIn",   32'(bus.dataIn),   32'hA1);
            if (c == 2) chk("rr.dataIn16", 32'(bus.dataIn16), 32'hB2B2);
            if (c == 4) chk("rr.dataIn32", 32'(bus.dataIn32), 32'hC3C3C3C3);
            tick();
        end
        bus.req8 = 1'b0; bus.req16 = 1'b0; bus.req32 = 1'b0;

        // Freeze for 5 cycles in slot 2 of a 32-bit frame.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req32 = 1'b1; bus.din32 = 32'hDEADBEEF;
        #1;
        chk("frz.ack32", 32'(bus.ack32), 32'h1);
        tick();
        bus.req32 = 1'b0;
        tick();
        chk("frz.slot2.dataS", 32'(bus.dataS), 32'h2);
        bus.enb = 1'b0;
        bus.req8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz.hold.dataS",    32'(bus.dataS),    32'h2);
            chk("frz.hold.dataIn32", 32'(bus.dataIn32), 32'hDEADBEEF);
            chk("frz.hold.K",        32'(bus.K),        32'h0);
            chk("frz.hold.busy",     32'(bus.busy),     32'h1);
            chk("frz.hold.acks",     32'({bus.ack32, bus.ack16, bus.ack8}), 32'h0);
        end
        bus.req8 = 1'b0;
        bus.enb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("frz.resume.dataS", 32'(bus.dataS), 32'h2);
            chk("frz.resume.K",     32'(bus.K),     32'h0);
        end
        tick();
        chk_idle("frz.after");

        // Reset in slot 3 of a 32-bit frame aborts it.
        bus.req32 = 1'b1; bus.din32 = 32'h12345678;
        #1;
        chk("abt.ack32", 32'(bus.ack32), 32'h1);
        tick();
        bus.req32 = 1'b0;
        tick();
        tick();
        chk("abt.slot3.dataS", 32'(bus.dataS), 32'h2);
        rst = 1'b0;
        bus.req8 = 1'b1;
        #1;
        chk("abt.ack8_in_rst", 32'(bus.ack8), 32'h0);
        tick();
        chk_idle("abt.after");
        chk("abt.dataIn32", 32'(bus.dataIn32), 32'h0);
        bus.req8 = 1'b0;

        // Skip insertion with interval 16 and a held 32-bit requester.
        tick();
        rst = 1'b1;
        bus_s.enb = 1'b1;
        bus_s.req32 = 1'b1;
        bus_s.din32 = 32'hCAFEF00D;
        #1;
        for (int c = 0; c < 38; c++) begin
            logic e_ack;
            logic e_k;
            e_ack = (c == 0 || c == 4 || c == 8 || c == 12 || c == 18 ||
                     c == 22 || c == 26 || c == 30 || c == 36);
            e_k   = (c == 0 || c == 17 || c == 18 || c == 35 || c == 36);
            chk($sformatf("skp.c%0d.ack32", c), 32'(bus_s.ack32), 32'(e_ack));
            chk($sformatf("skp.c%0d.K", c), 32'(bus_s.K), 32'(e_k));
            if (c == 17 || c == 35)
                chk($sformatf("skp.c%0d.com", c), 32'(bus_s.dataIn), 32'hBC);
            if (c == 18 || c == 36)
                chk($sformatf("skp.c%0d.skp", c), 32'(bus_s.dataIn), 32'h1C);
            if (c == 10)
                chk("skp.dataIn32", 32'(bus_s.dataIn32), 32'hCAFEF00D);
            tick();
        end
        bus_s.req32 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
